// File: rtl/route_allocator_if.sv
// Route allocator bus: groups the request, release, status and crossbar-select
// signals exchanged between the port controllers / datapath and the allocator.
//   req_valid    [N]        input i requests an output port
//   req_port     [N*RW]     slice i: requested output index of input i
//   relieve      [N]        input i releases the output it owns
//   grant_status [N]        input i currently owns an output
//   out_busy     [N]        output o locked to an owner
//   out_sel      [N*RW]     slice o: owning input index of output o (0 when idle)
// master = port controllers / datapath side, slave = allocator side.
interface route_allocator_if #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
);
  logic [N-1:0]               req_valid;
  logic [N*REQUEST_WIDTH-1:0] req_port;
  logic [N-1:0]               relieve;
  logic [N-1:0]               grant_status;
  logic [N-1:0]               out_busy;
  logic [N*REQUEST_WIDTH-1:0] out_sel;

  modport master (
    output req_valid, req_port, relieve,
    input  grant_status, out_busy, out_sel
  );

  modport slave (
    input  req_valid, req_port, relieve,
    output grant_status, out_busy, out_sel
  );
endinterface

// File: rtl/route_allocator.sv
// Switch-level output-port allocator. Each output port has a two-state
// IDLE/LOCKED FSM and a round-robin pointer; an idle output grants the first
// eligible requester at or after its pointer and then stays locked to that
// owner until the owner raises relieve.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - route_allocator_if.slave (requests in, status/select out)
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
module route_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  route_allocator_if.slave bus
);
  localparam int RW = REQUEST_WIDTH;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                st_q [N];
  state_e                st_d [N];
  logic [N-1:0][RW-1:0]  sel_q, sel_d;
  logic [N-1:0][RW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]          gs_q, gs_d;
  logic [N-1:0][N-1:0]   elig_s;

  // Eligible set per output: valid request for this output from a non-owner.
  // Port indices >= N never match any o, so they are dropped here.
  always_comb begin
    elig_s = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        elig_s[o][i] = bus.req_valid[i]
                     && (bus.req_port[i*RW +: RW] == RW'(o))
                     && !gs_q[i];
      end
    end
  end

  // Per-output next state: round-robin grant when idle, release on owner relieve.
  always_comb begin
    logic          found;
    logic [RW-1:0] win;
    int            idx;
    int            nxt;
    for (int o = 0; o < N; o++) begin
      st_d[o] = st_q[o];
    end
    sel_d = sel_q;
    ptr_d = ptr_q;
    for (int o = 0; o < N; o++) begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      nxt   = 0;
      case (st_q[o])
        ST_IDLE: begin
          for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q[o]) + k) % N;
            if (!found && elig_s[o][idx]) begin
              found = 1'b1;
              win   = idx[RW-1:0];
              nxt   = (idx + 1) % N;
            end else begin
              found = found;
            end
          end
          if (found) begin
            st_d[o]  = ST_LOCKED;
            sel_d[o] = win;
            ptr_d[o] = nxt[RW-1:0];
          end else begin
            st_d[o]  = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          // Only the owner's relieve counts; the freed output is re-granted
          // no earlier than the following edge.
          for (int i = 0; i < N; i++) begin
            if ((sel_q[o] == RW'(i)) && bus.relieve[i]) begin
              st_d[o]  = ST_IDLE;
              sel_d[o] = '0;
            end else begin
              found = found;
            end
          end
        end
        default: begin
          st_d[o]  = ST_IDLE;
          sel_d[o] = '0;
        end
      endcase
    end
  end

  // Ownership status follows the next-state locks so it is registered too.
  always_comb begin
    gs_d = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        gs_d[i] = gs_d[i] | ((st_d[o] == ST_LOCKED) && (sel_d[o] == RW'(i)));
      end
    end
  end

  // State, select, pointer and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < N; o++) begin
        st_q[o] <= ST_IDLE;
      end
      sel_q <= '0;
      ptr_q <= '0;
      gs_q  <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        st_q[o] <= st_d[o];
      end
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      gs_q  <= gs_d;
    end
  end

  // Drive the bus outputs from registers.
  always_comb begin
    bus.out_busy = '0;
    for (int o = 0; o < N; o++) begin
      bus.out_busy[o] = (st_q[o] == ST_LOCKED);
    end
    bus.out_sel      = sel_q;
    bus.grant_status = gs_q;
  end
endmodule

// File: tb/tb_route_allocator.sv
module tb_route_allocator;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  route_allocator_if #(.N(4), .REQUEST_WIDTH(2)) bus4 ();
  route_allocator_if #(.N(3), .REQUEST_WIDTH(2)) bus3 ();

  route_allocator #(.N(4), .REQUEST_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  route_allocator #(.N(3), .REQUEST_WIDTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] valid;
    logic [7:0] port;
    logic [3:0] relieve;
    logic [3:0] exp_busy;
    logic [3:0] exp_gs;
    logic [7:0] exp_sel;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input logic [3:0] busy, input logic [3:0] gs,
                        input logic [7:0] sel);
    check({name, ".busy"}, {28'd0, bus4.out_busy}, {28'd0, busy});
    check({name, ".gs"},   {28'd0, bus4.grant_status}, {28'd0, gs});
    check({name, ".sel"},  {24'd0, bus4.out_sel}, {24'd0, sel});
  endtask

  task automatic drive_idle();
    bus4.req_valid = 4'b0000;
    bus4.req_port  = 8'h00;
    bus4.relieve   = 4'b0000;
    bus3.req_valid = 3'b000;
    bus3.req_port  = 6'h00;
    bus3.relieve   = 3'b000;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] owners [5];
    int         blk;
    int         phase;
    checks = 0;
    errors = 0;

    // name, valid, port{p3,p2,p1,p0}, relieve, exp busy, exp gs, exp sel{o3,o2,o1,o0}
    vecs[0] = '{"idle",     4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 8'b00_00_00_00};
    vecs[1] = '{"grant1_3", 4'b0010, 8'b00_00_11_00, 4'b0000, 4'b1000, 4'b0010, 8'b01_00_00_00};
    vecs[2] = '{"hold",     4'b0000, 8'b00_00_00_00, 4'b0000, 4'b1000, 4'b0010, 8'b01_00_00_00};
    vecs[3] = '{"nonown",   4'b0000, 8'b00_00_00_00, 4'b0100, 4'b1000, 4'b0010, 8'b01_00_00_00};
    vecs[4] = '{"retarget", 4'b0010, 8'b00_00_00_00, 4'b0000, 4'b1000, 4'b0010, 8'b01_00_00_00};
    vecs[5] = '{"release",  4'b0000, 8'b00_00_00_00, 4'b0010, 4'b0000, 4'b0000, 8'b00_00_00_00};
    vecs[6] = '{"parallel", 4'b1111, 8'b01_00_11_10, 4'b0000, 4'b1111, 4'b1111, 8'b01_00_11_10};
    vecs[7] = '{"relall",   4'b0000, 8'b00_00_00_00, 4'b1111, 4'b0000, 4'b0000, 8'b00_00_00_00};

    // Reset state and quiet idle after release.
    do_reset();
    check4("reset", 4'b0000, 4'b0000, 8'h00);
    tick();
    tick();
    check4("post_reset", 4'b0000, 4'b0000, 8'h00);

    // Directed single-cycle vectors.
    for (int v = 0; v < 8; v++) begin
      bus4.req_valid = vecs[v].valid;
      bus4.req_port  = vecs[v].port;
      bus4.relieve   = vecs[v].relieve;
      tick();
      check4(vecs[v].name, vecs[v].exp_busy, vecs[v].exp_gs, vecs[v].exp_sel);
    end
    drive_idle();

    // Out-of-range port on the N=3 instance, alongside a legal request.
    bus3.req_valid = 3'b011;
    bus3.req_port  = 6'b00_10_11;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("n3.busy", {29'd0, bus3.out_busy}, {29'd0, 3'b100});
      check("n3.gs",   {29'd0, bus3.grant_status}, {29'd0, 3'b010});
      check("n3.sel",  {26'd0, bus3.out_sel}, {26'd0, 6'b01_00_00});
    end
    drive_idle();

    // Round robin on output 0 among in0, in2, in3; each owner relieves at the
    // second edge after its grant, then one idle cycle precedes the next owner.
    do_reset();
    owners[0] = 2'd0; owners[1] = 2'd2; owners[2] = 2'd3; owners[3] = 2'd0; owners[4] = 2'd2;
    bus4.req_valid = 4'b1101;
    bus4.req_port  = 8'h00;
    for (int e = 1; e <= 13; e++) begin
      blk   = (e - 1) / 3;
      phase = (e - 1) % 3;
      bus4.relieve = (phase == 2) ? (4'b0001 << owners[blk]) : 4'b0000;
      tick();
      if (phase == 2)
        check4("rr_gap", 4'b0000, 4'b0000, 8'h00);
      else
        check4("rr_own", 4'b0001, 4'b0001 << owners[blk], {6'd0, owners[blk]});
    end
    drive_idle();

    // Asynchronous reset mid-lock, then pointer of output 0 must be back at 0.
    do_reset();
    bus4.req_valid = 4'b1010;
    bus4.req_port  = 8'b10_00_00_00;
    tick();
    check4("lock0101", 4'b0101, 4'b1010, 8'b00_11_00_01);
    drive_idle();
    #3;
    rst = 1'b0;
    #1;
    check4("async_rst", 4'b0000, 4'b0000, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    bus4.req_valid = 4'b1010;
    bus4.req_port  = 8'h00;
    tick();
    check4("ptr_reset", 4'b0001, 4'b0010, 8'b00_00_00_01);
    drive_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
